// File: rtl/upscaler_pkg.sv
// Types and constants shared by the upscaler front end: pixel width, horizontal
// repetition factor, feeder state encoding and the FIFO entry layout.
package upscaler_pkg;

   localparam int PIX_W  = 24;
   localparam int H_REPS = 3;

   typedef enum logic {
      IDLE,
      RUN
   } feeder_state_t;

   typedef struct packed {
      logic             sof;
      logic [PIX_W-1:0] pixel;
   } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and full/empty flags.
// Writes while full and reads while empty are ignored; no pass-through.
module sync_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_feeder.sv
// Buffers source pixels and repeats each one H_REPS cycles into the upscaler,
// tracking frame position. FEEDER_UNDERRUN_EN adds the underrun_cnt port.
//
// state | meaning
// IDLE  | no frame open; popped entries without sof are dropped
// RUN   | frame open; x/y track the pixel shown (or next, during a bubble)
module pixel_feeder
   import upscaler_pkg::*;
#(
   parameter int IMG_W = 384,
   parameter int IMG_H = 216,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_sof,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [PIX_W-1:0] up_pixel,
   output logic             up_valid,
   output logic             frame_done,
   output logic             sof_err
`ifdef FEEDER_UNDERRUN_EN
   ,output logic [15:0]     underrun_cnt
`endif
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
   localparam logic [1:0]    LAST_REP = 2'(H_REPS - 1);

   feeder_state_t    state, state_n;
   logic [1:0]       rep, rep_n;
   logic [XW-1:0]    x, x_n;
   logic [YW-1:0]    y, y_n;
   logic [PIX_W-1:0] up_pixel_n;
   logic             up_valid_n;
   logic             frame_done_n;
   logic             sof_err_n;

   fifo_entry_t      wr_entry;
   fifo_entry_t      head;
   logic             full;
   logic             empty;
   logic             pop;
   logic             last_rep;
   logic             last_pix;

   assign s_ready  = !full;
   assign wr_entry = '{sof: s_sof, pixel: s_data};

   sync_fifo #(
      .WIDTH($bits(fifo_entry_t)),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (s_valid),
      .wr_data(wr_entry),
      .rd_en  (pop),
      .rd_data(head),
      .full   (full),
      .empty  (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rep        <= '0;
         x          <= '0;
         y          <= '0;
         up_pixel   <= '0;
         up_valid   <= 1'b0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
      end else begin
         state      <= state_n;
         rep        <= rep_n;
         x          <= x_n;
         y          <= y_n;
         up_pixel   <= up_pixel_n;
         up_valid   <= up_valid_n;
         frame_done <= frame_done_n;
         sof_err    <= sof_err_n;
      end
   end

   always_comb begin
      state_n      = state;
      rep_n        = rep;
      x_n          = x;
      y_n          = y;
      up_pixel_n   = up_pixel;
      up_valid_n   = up_valid;
      frame_done_n = 1'b0;
      sof_err_n    = 1'b0;

      last_rep = (state == RUN) && up_valid && (rep == LAST_REP);
      last_pix = last_rep && (x == X_LAST) && (y == Y_LAST);
      pop      = !empty && ((state == IDLE) || !up_valid || (rep == LAST_REP));

      if (up_valid && (rep != LAST_REP)) rep_n = rep + 1'b1;

      // Finishing a pixel advances the position; a pop below may reload at once.
      if (last_rep) begin
         up_valid_n = 1'b0;
         if (x == X_LAST) begin
            x_n = '0;
            y_n = (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x_n = x + 1'b1;
         end
         if (last_pix) begin
            frame_done_n = 1'b1;
            state_n      = IDLE;
         end
      end

      if (pop) begin
         if (head.sof) begin
            if ((state == RUN) && ((x_n != '0) || (y_n != '0))) sof_err_n = 1'b1;
            x_n        = '0;
            y_n        = '0;
            state_n    = RUN;
            up_pixel_n = head.pixel;
            up_valid_n = 1'b1;
            rep_n      = '0;
         end else if (state_n == RUN) begin
            up_pixel_n = head.pixel;
            up_valid_n = 1'b1;
            rep_n      = '0;
         end
      end
   end

`ifdef FEEDER_UNDERRUN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underrun_cnt <= '0;
      end else if ((state == RUN) && !up_valid && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_feeder.sv
// Testbench for pixel_feeder (IMG_W=4, IMG_H=2, DEPTH=4) against a transaction
// model that schedules each accepted beat's display window arithmetically.
module tb_pixel_feeder;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int D    = 4;
   localparam int MAXC = 4000;

   logic        clk;
   logic        rst;
   logic [23:0] s_data;
   logic        s_sof;
   logic        s_valid;
   logic        s_ready;
   logic [23:0] up_pixel;
   logic        up_valid;
   logic        frame_done;
   logic        sof_err;
`ifdef FEEDER_UNDERRUN_EN
   logic [15:0] underrun_cnt;
`endif

   pixel_feeder #(.IMG_W(W), .IMG_H(H), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_data    (s_data),
      .s_sof     (s_sof),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .up_pixel  (up_pixel),
      .up_valid  (up_valid),
      .frame_done(frame_done),
      .sof_err   (sof_err)
`ifdef FEEDER_UNDERRUN_EN
      ,.underrun_cnt(underrun_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Expected outputs per cycle (index = number of rising edges seen).
   bit          exp_v [MAXC];
   logic [23:0] exp_p [MAXC];
   bit          exp_d [MAXC];
   bit          exp_e [MAXC];

   int pop_q[$];
   int prev_pop;
   bit prev_shown;
   bit in_frame;
   int pos;
   bit run_open;
   int prev_shown_pop;
   int exp_under;
   int obs_v;
   int obs_d;
   int obs_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic model_reset();
      pop_q.delete();
      prev_pop   = -10;
      prev_shown = 1'b0;
      in_frame   = 1'b0;
      pos        = 0;
      run_open   = 1'b0;
      prev_shown_pop = 0;
      exp_under  = 0;
      for (int i = cyc + 1; i < MAXC; i++) begin
         exp_v[i] = 1'b0;
         exp_p[i] = '0;
         exp_d[i] = 1'b0;
         exp_e[i] = 1'b0;
      end
   endtask

   // A beat accepted at edge t is popped at the first edge where the FIFO holds
   // it and the previous entry is done: 3 edges for a shown pixel, 1 for a drop.
   task automatic model_beat(input int t, input bit sof, input logic [23:0] d);
      int p;
      bit shown;
      p = t + 1;
      if (p < prev_pop + (prev_shown ? 3 : 1)) p = prev_pop + (prev_shown ? 3 : 1);
      pop_q.push_back(p);
      shown = 1'b0;
      if (sof) begin
         if (in_frame && p < MAXC) exp_e[p] = 1'b1;
         in_frame = 1'b1;
         pos = 0;
      end
      if (in_frame) begin
         shown = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (p + k < MAXC) begin
               exp_v[p+k] = 1'b1;
               exp_p[p+k] = d;
            end
         end
         if (run_open) exp_under += p - (prev_shown_pop + 3);
         pos++;
         if (pos == W * H) begin
            if (p + 3 < MAXC) exp_d[p+3] = 1'b1;
            in_frame = 1'b0;
            run_open = 1'b0;
         end else begin
            run_open = 1'b1;
         end
         prev_shown_pop = p;
      end
      prev_pop   = p;
      prev_shown = shown;
   endtask

   task automatic check_cycle();
      while (pop_q.size() > 0 && pop_q[0] <= cyc) void'(pop_q.pop_front());
      chk("s_ready", {31'b0, s_ready}, {31'b0, (pop_q.size() < D)});
      chk("up_valid", {31'b0, up_valid}, {31'b0, exp_v[cyc]});
      if (exp_v[cyc]) chk("up_pixel", {8'b0, up_pixel}, {8'b0, exp_p[cyc]});
      chk("frame_done", {31'b0, frame_done}, {31'b0, exp_d[cyc]});
      chk("sof_err", {31'b0, sof_err}, {31'b0, exp_e[cyc]});
      if (up_valid) obs_v++;
      if (frame_done) obs_d++;
      if (sof_err) obs_e++;
   endtask

   // Called at a falling edge: drive, advance one clock, check at the next fall.
   task automatic step(input bit v, input bit sof, input logic [23:0] d, output bit beat);
      s_valid = v;
      s_sof   = sof;
      s_data  = d;
      #1;
      beat = v && s_ready && !rst;
      @(posedge clk);
      cyc++;
      if (beat) model_beat(cyc, sof, d);
      @(negedge clk);
      check_cycle();
   endtask

   task automatic idle(input int n);
      bit b;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, b);
   endtask

   task automatic send(input bit sof, input logic [23:0] d);
      bit b;
      int tries;
      b = 1'b0;
      tries = 0;
      while (!b && tries < 30) begin
         step(1'b1, sof, d, b);
         tries++;
      end
      chk("send_accepted", {31'b0, b}, 32'd1);
   endtask

   task automatic send_frame(input int gap);
      for (int i = 0; i < W * H; i++) begin
         send(i == 0, 24'($urandom));
         idle(gap);
      end
   endtask

   initial begin
      bit b;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = '0;
      model_reset();
      @(negedge clk);
      check_cycle();
      chk("rst_up_pixel", {8'b0, up_pixel}, 32'h0);
`ifdef FEEDER_UNDERRUN_EN
      chk("rst_underrun", {16'b0, underrun_cnt}, 32'h0);
`endif
      idle(2);
      rst = 1'b0;
      idle(2);

      // Single pixel
      obs_v = 0;
      send(1'b1, 24'h123456);
      idle(8);
      chk("single_valid_cycles", obs_v, 32'd3);

      // Full frame with the source always valid; DEPTH=4 forces backpressure
      obs_v = 0; obs_d = 0; obs_e = 0;
      send_frame(0);
      idle(30);
      chk("frame_valid_cycles", obs_v, 32'd24);
      chk("frame_done_count", obs_d, 32'd1);
      chk("abandon_sof_err", obs_e, 32'd1);

      // Underrun: one pixel every 5 cycles
      obs_v = 0;
      send_frame(4);
      idle(10);
      chk("underrun_valid_cycles", obs_v, 32'd24);
`ifdef FEEDER_UNDERRUN_EN
      chk("underrun_cnt", {16'b0, underrun_cnt}, exp_under);
`endif

      // Non-sof pixels while idle are dropped
      obs_v = 0;
      for (int i = 0; i < 3; i++) send(1'b0, 24'($urandom));
      idle(8);
      chk("discard_valid_cycles", obs_v, 32'd0);

      // sof at x=2 restarts the frame
      obs_d = 0; obs_e = 0;
      send(1'b1, 24'hA00000);
      send(1'b0, 24'hA00001);
      send(1'b1, 24'hB00000);
      for (int i = 1; i < W * H; i++) send(1'b0, 24'hB00000 + 24'(i));
      idle(30);
      chk("restart_sof_err", obs_e, 32'd1);
      chk("restart_frame_done", obs_d, 32'd1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 24'($urandom), b);
      idle(40);
`ifdef FEEDER_UNDERRUN_EN
      chk("random_underrun_cnt", {16'b0, underrun_cnt}, exp_under);
`endif

      // Reset while a pixel is in its second repetition, with the FIFO loaded
      send(1'b1, 24'hC0FFEE);
      send(1'b0, 24'h111111);
      send(1'b0, 24'h222222);
      chk("pre_rst_valid", {31'b0, up_valid}, 32'd1);
      rst = 1'b1;
      s_valid = 1'b0;
      #1;
      model_reset();
      chk("rst_async_up_valid", {31'b0, up_valid}, 32'd0);
      chk("rst_async_up_pixel", {8'b0, up_pixel}, 32'h0);
      chk("rst_async_s_ready", {31'b0, s_ready}, 32'd1);
      chk("rst_async_frame_done", {31'b0, frame_done}, 32'd0);
`ifdef FEEDER_UNDERRUN_EN
      chk("rst_async_underrun", {16'b0, underrun_cnt}, 32'h0);
`endif
      @(negedge clk);
      idle(2);
      rst = 1'b0;
      obs_v = 0;
      idle(6);
      chk("post_rst_valid_cycles", obs_v, 32'd0);

      // Normal frame after reset
      obs_d = 0;
      send_frame($urandom_range(0, 2));
      idle(30);
      chk("post_rst_frame_done", obs_d, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pixel_feeder.md
# pixel_feeder

Upstream stage of the upscaler datapath. Accepts source RGB888 pixels over a valid/ready handshake and buffers them in a small FIFO. Presents each pixel to the upscaler input (`pixel_in`/`input_valid`) for exactly three contiguous valid cycles, so the upscaler's mod-3 phase counter shifts its line buffer once per source pixel. Tracks frame position and reports frame completion and framing errors.

## Interface
- `IMG_W`, 384: source pixels per line.
- `IMG_H`, 216: source lines per frame.
- `DEPTH`, 8: FIFO depth in pixels; power of two, ≥2.
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `s_data`  in  24  source pixel {R,G,B}.
- `s_sof`  in  1  marks the first pixel of a frame; qualified by `s_valid`.
- `s_valid`  in  1  source data valid.
- `s_ready`  out  1  feeder can accept a pixel this cycle.
- `up_pixel`  out  24  drives upscaler `pixel_in`.
- `up_valid`  out  1  drives upscaler `input_valid`.
- `frame_done`  out  1  one-cycle pulse after the last repetition of pixel (IMG_W-1, IMG_H-1).
- `sof_err`  out  1  one-cycle pulse when `s_sof` arrives mid-frame.
- `underrun_cnt`  out  16  bubble count; present only with `FEEDER_UNDERRUN_EN`.

## Operation
- Transfer: a source beat occurs when `s_valid && s_ready`. `s_ready = !full`; the flag is derived from the registered FIFO count. A beat writes {`s_sof`, `s_data`} into the FIFO.
- Full condition: when the FIFO is full, `s_ready` is low. No push/pop pass-through occurs.
- Repetition counter `rep` (0..2): pop the FIFO when (`rep`==2, or no pixel is loaded) and the FIFO is non-empty. On pop, load `up_pixel`, set `up_valid`=1, and set `rep`=0. Otherwise, when `up_valid`=1 and `rep`<2, increment `rep`.
- Contiguity: the three repetitions of one pixel are always contiguous. Bubbles (`up_valid`=0) occur only between pixels, when the FIFO is empty at `rep`==2.
- States:
  - IDLE: entered from reset. Popped entries without the sof flag are discarded; nothing is driven and `up_valid` stays 0. A popped entry with sof is loaded, the counters are set to x=0, y=0, and the state moves to RUN.
  - RUN: after the third repetition of each pixel, advance x. At x==IMG_W-1, wrap x to 0 and increment y. After the last pixel of the frame, pulse `frame_done` and move to IDLE.
- Mid-frame sof: a popped sof entry in RUN, other than at x=0, y=0, pulses `sof_err` on that pop. The current frame is abandoned, and the entry becomes pixel (0,0) of a new frame; the state stays RUN.
- Reset mid-operation:
  - FIFO is emptied; state goes to IDLE and `rep`/x/y to 0.
  - All outputs reset: `up_pixel`=0, `up_valid`=0, `frame_done`=0, `sof_err`=0, `underrun_cnt`=0. `s_ready` is 1 after reset (empty FIFO).

## Timing
- All outputs except `s_ready` are registered.
- Latency: with the FIFO empty, a beat at edge N puts the pixel on `up_pixel` with `up_valid`=1 in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: the steady state is 1 source pixel per 3 cycles. `s_ready` toggles accordingly when the source is faster.
- `frame_done` is high for the single cycle after the last `up_valid` repetition of the frame.
- The sof flag and pixel data travel together through the FIFO, so framing is evaluated at pop time, not at accept time.

## Configuration
- `FEEDER_UNDERRUN_EN` defined: `underrun_cnt` port exists. It increments, saturating at 0xFFFF, on every RUN-state cycle with `up_valid`=0, and resets only on `rst`.
- `FEEDER_UNDERRUN_EN` undefined: the port and its logic are absent. Datapath behaviour is identical.

## Structure
- Shared package `upscaler_pkg` holds:
  - `PIX_W`=24 and `H_REPS`=3; the latter is also used by the phase counter.
  - Feeder state typedef {IDLE, RUN}.
  - The 25-bit FIFO entry typedef {sof, pixel}.
- One sub-module: `sync_fifo`, parameterised by width and depth, with registered count and `full`/`empty` flags. All framing and repetition logic stays in `pixel_feeder`.

## Test plan
- Single pixel: reset, then a sof beat with 0x123456. `up_valid` high for exactly 3 cycles with `up_pixel`=0x123456, starting 2 cycles after the beat.
- Full frame, small configuration: IMG_W=4, IMG_H=2, source always valid. Expect 24 `up_valid` cycles in groups of 3 with no intra-pixel gap, and `frame_done` one cycle after the 24th.
- Backpressure: DEPTH=4, source always valid. `s_ready` falls once 4 entries are held; afterwards exactly one beat is accepted per 3 cycles, and no pixel is lost or duplicated.
- Underrun: source supplies 1 pixel per 5 cycles. Expect 2-cycle bubbles between pixels, with `underrun_cnt` +2 per pixel when `FEEDER_UNDERRUN_EN` is defined.
- Framing errors:
  - 3 non-sof pixels after reset are discarded with no `up_valid`.
  - sof at x=2 of a frame pulses `sof_err` and restarts the frame, with `frame_done` only after IMG_W·IMG_H further pixels.
- Reset mid-pixel: assert `rst` during `rep`=1. Outputs go to 0 immediately, and the FIFO is empty (`s_ready`=1) after release.
